// File: rtl/climate_ctrl_multi.sv
// climate_ctrl_multi: N-channel hysteresis climate controller with
// ASCII command decode and a rotating display tick for the LCD path.
`timescale 1ns/1ps
module climate_ctrl_multi #(
    parameter int              N_CH        = 2,
    parameter int              DATA_W      = 8,
    parameter logic [N_CH-1:0] POL         = N_CH'(1),
    parameter int              DEF_HI      = 18,
    parameter int              DEF_LO      = 10,
    parameter int              REFRESH_CYC = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] sensor_data,
    input  logic [7:0]             chr_cmd,
    input  logic [7:0]             chr_ch,
    input  logic [7:0]             chr_val0,
    input  logic [7:0]             chr_val1,
    input  logic                   rx_msg_done,
    output logic [N_CH-1:0]        act,
    output logic [N_CH-1:0]        manual,
    output logic                   cmd_ack,
    output logic                   cmd_err,
    output logic                   disp_tick,
    output logic [2:0]             disp_ch,
    output logic [DATA_W-1:0]      disp_val
);

    localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [63:0] MAXV = (64'd1 << DATA_W) - 64'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_APPLY,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_H,
        OP_L,
        OP_M,
        OP_A
    } op_t;

    state_t state_q, state_d;

    logic done1_q, done2_q;
    logic rise;

    logic [7:0] cmd_q, chb_q, b0_q, b1_q;

    op_t              op_q, op_d;
    logic [2:0]       ch_q;
    logic [DATA_W-1:0] val_q;
    logic             mval_q, mval_d;
    logic             err_q, bad_d;

    logic [DATA_W-1:0] hi_q [N_CH];
    logic [DATA_W-1:0] hi_d [N_CH];
    logic [DATA_W-1:0] lo_q [N_CH];
    logic [DATA_W-1:0] lo_d [N_CH];
    logic [N_CH-1:0]   man_q, man_d;
    logic [N_CH-1:0]   act_q, act_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick_q;
    logic [2:0]        dch_q;
    logic [2:0]        nxt_q;
    logic [DATA_W-1:0] dval_q;
    logic [DATA_W-1:0] nxt_val;

    logic [7:0]        ch_n, d0, d1, v_w;
    logic [DATA_W-1:0] v_dw, sel_hi, sel_lo;
    logic              dig_ch, dig_0, dig_1, ch_ok, rng_ok;

    function automatic logic is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    assign rise = done1_q & ~done2_q;

    // Two-stage sampling of rx_msg_done for the registered edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done1_q <= 1'b0;
            done2_q <= 1'b0;
        end else begin
            done1_q <= rx_msg_done;
            done2_q <= done1_q;
        end
    end

    // Command FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Command FSM next state; edges outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rise) state_d = S_CHECK;
            S_CHECK: state_d = S_APPLY;
            S_APPLY: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ack = (state_q == S_RESP) && !err_q;
    assign cmd_err = (state_q == S_RESP) &&  err_q;

    // Capture the command bytes when a new message is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= 8'h00;
            chb_q <= 8'h00;
            b0_q  <= 8'h00;
            b1_q  <= 8'h00;
        end else if (state_q == S_IDLE && rise) begin
            cmd_q <= chr_cmd;
            chb_q <= chr_ch;
            b0_q  <= chr_val0;
            b1_q  <= chr_val1;
        end
    end

    // Decode and validate the latched command; 'A' ignores value bytes,
    // 'M' only looks at the units byte
    always_comb begin
        dig_ch = is_dig(chb_q);
        dig_0  = is_dig(b0_q);
        dig_1  = is_dig(b1_q);
        ch_n   = chb_q - 8'h30;
        d0     = b0_q - 8'h30;
        d1     = b1_q - 8'h30;
        v_w    = d0 * 8'd10 + d1;
        v_dw   = DATA_W'(v_w);
        rng_ok = (64'(v_w) <= MAXV);
        ch_ok  = dig_ch && (ch_n < 8'(N_CH));
        sel_hi = '0;
        sel_lo = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_n == 8'(c)) begin
                sel_hi = hi_q[c];
                sel_lo = lo_q[c];
            end
        end
        mval_d = (b1_q != 8'h30);
        op_d   = OP_A;
        bad_d  = !ch_ok;
        case (cmd_q)
            8'h48: begin
                op_d = OP_H;
                if (!dig_0 || !dig_1 || !rng_ok || v_dw < sel_lo)
                    bad_d = 1'b1;
            end
            8'h4C: begin
                op_d = OP_L;
                if (!dig_0 || !dig_1 || !rng_ok || v_dw > sel_hi)
                    bad_d = 1'b1;
            end
            8'h4D: begin
                op_d = OP_M;
                if (!dig_1) bad_d = 1'b1;
            end
            8'h41: op_d = OP_A;
            default: bad_d = 1'b1;
        endcase
    end

    // Register decode results during CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_A;
            ch_q   <= 3'd0;
            val_q  <= '0;
            mval_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == S_CHECK) begin
            op_q   <= op_d;
            ch_q   <= ch_n[2:0];
            val_q  <= v_dw;
            mval_q <= mval_d;
            err_q  <= bad_d;
        end
    end

    // Per-channel hysteresis evaluation plus the APPLY write
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        man_d = man_q;
        act_d = act_q;
        for (int c = 0; c < N_CH; c++) begin
            if (!man_q[c]) begin
                if (POL[c]) begin
                    if (sensor_data[c*DATA_W +: DATA_W] > hi_q[c])
                        act_d[c] = 1'b1;
                    else if (sensor_data[c*DATA_W +: DATA_W] < lo_q[c])
                        act_d[c] = 1'b0;
                end else begin
                    if (sensor_data[c*DATA_W +: DATA_W] < lo_q[c])
                        act_d[c] = 1'b1;
                    else if (sensor_data[c*DATA_W +: DATA_W] > hi_q[c])
                        act_d[c] = 1'b0;
                end
            end
            if (state_q == S_APPLY && !err_q && ch_q == 3'(c)) begin
                unique case (op_q)
                    OP_H: hi_d[c] = val_q;
                    OP_L: lo_d[c] = val_q;
                    OP_M: begin
                        man_d[c] = 1'b1;
                        act_d[c] = mval_q;
                    end
                    OP_A: begin
                        man_d[c] = 1'b0;
                        act_d[c] = act_q[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                hi_q[c] <= DATA_W'(DEF_HI);
                lo_q[c] <= DATA_W'(DEF_LO);
            end
            man_q <= '0;
            act_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            man_q <= man_d;
            act_q <= act_d;
        end
    end

    assign act    = act_q;
    assign manual = man_q;

    // Sensor value of the channel shown at the next tick
    always_comb begin
        nxt_val = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (nxt_q == 3'(c)) nxt_val = sensor_data[c*DATA_W +: DATA_W];
        end
    end

    // Display refresh counter and rotating channel pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            dch_q  <= 3'd0;
            nxt_q  <= 3'd0;
            dval_q <= '0;
        end else if (cnt_q == CNT_W'(REFRESH_CYC - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            dch_q  <= nxt_q;
            dval_q <= nxt_val;
            nxt_q  <= (nxt_q == 3'(N_CH - 1)) ? 3'd0 : nxt_q + 3'd1;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
        end
    end

    assign disp_tick = tick_q;
    assign disp_ch   = dch_q;
    assign disp_val  = dval_q;

endmodule

// File: tb/tb_climate_ctrl_multi.sv
// tb_climate_ctrl_multi: directed and randomized checks of
// climate_ctrl_multi against a behavioural reference model.
`timescale 1ns/1ps
module tb_climate_ctrl_multi;

    localparam int N = 2;
    localparam int W = 8;
    localparam int R = 4;
    localparam int DH = 18;
    localparam int DL = 10;
    localparam logic [N-1:0] P = 2'b01;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] sensor_data = '0;
    logic [7:0]     chr_cmd = 8'h00;
    logic [7:0]     chr_ch = 8'h00;
    logic [7:0]     chr_val0 = 8'h00;
    logic [7:0]     chr_val1 = 8'h00;
    logic           rx_msg_done = 1'b0;
    logic [N-1:0]   act, manual;
    logic           cmd_ack, cmd_err, disp_tick;
    logic [2:0]     disp_ch;
    logic [W-1:0]   disp_val;

    climate_ctrl_multi #(
        .N_CH(N), .DATA_W(W), .POL(P),
        .DEF_HI(DH), .DEF_LO(DL), .REFRESH_CYC(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_data(sensor_data),
        .chr_cmd(chr_cmd), .chr_ch(chr_ch),
        .chr_val0(chr_val0), .chr_val1(chr_val1),
        .rx_msg_done(rx_msg_done), .act(act), .manual(manual),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err),
        .disp_tick(disp_tick), .disp_ch(disp_ch), .disp_val(disp_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int hi_m [N];
    int lo_m [N];
    bit man_m [N];
    bit act_m [N];
    int sens_m [N];
    int tick_n, nxt_m, exp_dch, exp_dval;
    bit exp_tick, exp_ack, exp_err, apply_now;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] b);
        return b >= "0" && b <= "9";
    endfunction

    function automatic bit cmd_bad();
        int ch, v;
        if (!is_dig(chr_ch)) return 1;
        ch = int'(chr_ch) - 48;
        if (ch >= N) return 1;
        v = (int'(chr_val0) - 48) * 10 + (int'(chr_val1) - 48);
        case (chr_cmd)
            "H": return !is_dig(chr_val0) || !is_dig(chr_val1) ||
                        v > 255 || v < lo_m[ch];
            "L": return !is_dig(chr_val0) || !is_dig(chr_val1) ||
                        v > 255 || v > hi_m[ch];
            "M": return !is_dig(chr_val1);
            "A": return 0;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            hi_m[c] = DH;
            lo_m[c] = DL;
            man_m[c] = 0;
            act_m[c] = 0;
        end
        tick_n = 0;
        nxt_m = 0;
        exp_tick = 0;
        exp_dch = 0;
        exp_dval = 0;
        exp_ack = 0;
        exp_err = 0;
        apply_now = 0;
    endtask

    task automatic model_edge();
        bit old [N];
        bit too_high, too_low;
        int ch, v;
        old = act_m;
        for (int c = 0; c < N; c++) begin
            too_high = sens_m[c] > hi_m[c];
            too_low  = sens_m[c] < lo_m[c];
            if (!man_m[c] && (too_high || too_low))
                act_m[c] = P[c] ? too_high : too_low;
        end
        exp_ack = 0;
        exp_err = 0;
        if (apply_now) begin
            apply_now = 0;
            exp_err = cmd_bad();
            exp_ack = !exp_err;
            if (exp_ack) begin
                ch = int'(chr_ch) - 48;
                v = (int'(chr_val0) - 48) * 10 + (int'(chr_val1) - 48);
                case (chr_cmd)
                    "H": hi_m[ch] = v;
                    "L": lo_m[ch] = v;
                    "M": begin
                        man_m[ch] = 1;
                        act_m[ch] = (chr_val1 != "0");
                    end
                    default: begin
                        man_m[ch] = 0;
                        act_m[ch] = old[ch];
                    end
                endcase
            end
        end
        tick_n++;
        exp_tick = (tick_n % R == 0);
        if (exp_tick) begin
            exp_dch = nxt_m;
            exp_dval = sens_m[nxt_m];
            nxt_m = (nxt_m + 1) % N;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ea, em;
        for (int c = 0; c < N; c++) begin
            ea[c] = act_m[c];
            em[c] = man_m[c];
        end
        chk("act", act, ea);
        chk("manual", manual, em);
        chk("cmd_ack", cmd_ack, exp_ack);
        chk("cmd_err", cmd_err, exp_err);
        chk("disp_tick", disp_tick, exp_tick);
        chk("disp_ch", disp_ch, exp_dch);
        chk("disp_val", disp_val, exp_dval);
    endtask

    task automatic set_sens(input int a, input int b);
        sens_m[0] = a;
        sens_m[1] = b;
        sensor_data = {W'(b), W'(a)};
    endtask

    task automatic rand_sens();
        for (int c = 0; c < N; c++) begin
            sens_m[c] = $urandom_range(0, 70);
            sensor_data[c*W +: W] = W'(sens_m[c]);
        end
    endtask

    task automatic step(input bit rnd);
        if (rnd) rand_sens();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_msg_done = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // want: 0 = ack, 1 = err, 2 = whatever the model says
    task automatic send_cmd(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] a, input logic [7:0] b,
                            input bit rnd, input int want);
        chr_cmd = c;
        chr_ch = h;
        chr_val0 = a;
        chr_val1 = b;
        rx_msg_done = 1'b1;
        step(rnd);
        step(rnd);
        step(rnd);
        apply_now = 1;
        step(rnd);
        if (want == 0) chk("lit_ack", {cmd_ack, cmd_err}, 2'b10);
        if (want == 1) chk("lit_err", {cmd_ack, cmd_err}, 2'b01);
        rx_msg_done = 1'b0;
        step(rnd);
        step(rnd);
    endtask

    logic [7:0] cmds [5];

    initial begin
        cmds[0] = "H";
        cmds[1] = "L";
        cmds[2] = "M";
        cmds[3] = "A";
        cmds[4] = "Z";
        set_sens(12, 12);
        @(negedge clk);
        do_reset();

        set_sens(19, 12);
        step(0);
        chk("t1_on", act[0], 1'b1);
        set_sens(15, 12);
        step(0);
        chk("t1_hold1", act[0], 1'b1);
        set_sens(9, 12);
        step(0);
        chk("t1_off", act[0], 1'b0);
        set_sens(10, 12);
        step(0);
        chk("t1_hold0", act[0], 1'b0);

        send_cmd("H", "1", "5", "5", 0, 0);
        set_sens(19, 5);
        step(0);
        set_sens(19, 40);
        step(0);
        chk("t2_hi55", act[1], 1'b1);
        set_sens(19, 56);
        step(0);
        chk("t2_above", act[1], 1'b0);
        send_cmd("L", "1", "9", "9", 0, 1);

        set_sens(0, 12);
        send_cmd("M", "0", " ", "1", 0, 0);
        chk("t3_man", {manual[0], act[0]}, 2'b11);
        send_cmd("A", "0", "x", "x", 0, 0);
        chk("t3_auto", {manual[0], act[0]}, 2'b00);

        send_cmd("H", "9", "1", "2", 0, 1);
        send_cmd("H", "0", "A", "5", 0, 1);
        send_cmd("Z", "0", "1", "2", 0, 1);
        send_cmd("H", "0", "0", "9", 0, 1);

        for (int i = 0; i < 8; i++) step(1);

        chr_cmd = "L";
        chr_ch = "1";
        chr_val0 = "0";
        chr_val1 = "5";
        rx_msg_done = 1'b1;
        step(0);
        step(0);
        step(0);
        do_reset();
        for (int i = 0; i < 6; i++) step(0);
        set_sens(12, 5);
        step(0);
        set_sens(12, 30);
        step(0);
        chk("t6_hi_def", act[1], 1'b0);
        set_sens(12, 7);
        step(0);
        chk("t6_lo_def", act[1], 1'b1);

        chr_cmd = "H";
        chr_ch = "0";
        chr_val0 = "1";
        chr_val1 = "2";
        rx_msg_done = 1'b1;
        step(0);
        rx_msg_done = 1'b0;
        step(0);
        rx_msg_done = 1'b1;
        step(0);
        apply_now = 1;
        step(0);
        chk("t6_ack1", {cmd_ack, cmd_err}, 2'b10);
        for (int i = 0; i < 4; i++) step(0);
        rx_msg_done = 1'b0;
        for (int i = 0; i < 3; i++) step(0);
        set_sens(13, 12);
        step(0);
        chk("t6_hi12", act[0], 1'b1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_cmd(cmds[$urandom_range(0, 4)],
                         8'("0" + $urandom_range(0, 2)),
                         ($urandom_range(0, 15) == 0) ? 8'h78 :
                             8'("0" + $urandom_range(0, 9)),
                         8'("0" + $urandom_range(0, 9)), 1, 2);
            end else begin
                step(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
